// File: rtl/bcd_seq_converter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_converter_pkg
// Brief    : State encoding and DIGITS legality helper for bcd_seq_converter.
// Revision : 1.0
// ============================================================================
package bcd_seq_converter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Decimal digits needed to print the largest unsigned bin_w-bit value.
  function automatic int min_digits(input int bin_w);
    logic [127:0] v;
    int           d;
    v = (128'd1 << bin_w) - 128'd1;
    d = 0;
    while (v != 128'd0) begin
      v = v / 128'd10;
      d = d + 1;
    end
    return (d < 1) ? 1 : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : One double-dabble cell: adds 3 to a BCD digit that is >= 5.
// Revision : 1.0
// ============================================================================
module bcd_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_seq_converter
// Brief    : Iterative shift-and-add-3 binary-to-BCD converter, signed/unsigned.
// Revision : 1.0
// ============================================================================
module bcd_seq_converter
  import bcd_seq_converter_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  signed_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  if (BIN_W < 4) begin : g_bin_w_check
    $fatal(1, "bcd_seq_converter: BIN_W must be at least 4");
  end
  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $fatal(1, "bcd_seq_converter: DIGITS too small to hold 2^BIN_W-1");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic             neg_pend_q, neg_pend_d;
  logic [BCD_W-1:0] bcd_out_q, bcd_out_d;
  logic             neg_q, neg_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic                   w_accept;
  logic                   w_in_neg;
  logic [BIN_W-1:0]       w_in_mag;
  logic [BCD_W-1:0]       w_acc_adj;
  logic [BCD_W+BIN_W-1:0] w_shifted;

  assign w_accept = in_valid && in_ready_q;
  assign w_in_neg = signed_mode & bin_in[BIN_W-1];
  // Two's-complement negate stays BIN_W wide so the most-negative value maps to 2^(BIN_W-1).
  assign w_in_mag = w_in_neg ? (~bin_in + BIN_W'(1)) : bin_in;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit_adj
    bcd_digit_adj u_adj (
      .digit_in  (acc_q[4*i +: 4]),
      .digit_out (w_acc_adj[4*i +: 4])
    );
  end

  assign w_shifted = {w_acc_adj, mag_q} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      acc_q       <= '0;
      neg_pend_q  <= 1'b0;
      bcd_out_q   <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      neg_pend_q  <= neg_pend_d;
      bcd_out_q   <= bcd_out_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_accept) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    neg_pend_d  = neg_pend_q;
    bcd_out_d   = bcd_out_q;
    neg_d       = neg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          neg_pend_d = w_in_neg;
          mag_d      = w_in_mag;
          acc_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          in_ready_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        {acc_d, mag_d} = w_shifted;
        cnt_d          = cnt_q - CNT_W'(1);
        // Published result and sign only move on the final iteration.
        if (cnt_q == CNT_W'(1)) begin
          bcd_out_d   = w_shifted[BCD_W+BIN_W-1 -: BCD_W];
          neg_d       = neg_pend_q;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_out_q;
  assign neg       = neg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_seq_converter
// Brief    : Directed scoreboard bench for bcd_seq_converter (16/5 and 8/3).
// Revision : 1.0
// ============================================================================
module tb_bcd_seq_converter;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, signed_mode, out_valid, out_ready, neg;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;

  logic        in_valid_8, in_ready_8, signed_mode_8, out_valid_8, neg_8;
  logic        out_ready_8;
  logic [7:0]  bin_in_8;
  logic [11:0] bcd_out_8;

  always #5 clk = ~clk;

  bcd_seq_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .bcd_out(bcd_out), .neg(neg)
  );

  bcd_seq_converter #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .bin_in(bin_in_8), .signed_mode(signed_mode_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .bcd_out(bcd_out_8), .neg(neg_8)
  );

  typedef struct packed {
    logic [19:0] bcd;
    logic        neg;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer magnitude then decimal digits by division.
  function automatic exp_t model(input int unsigned b, input int w, input logic sm);
    exp_t        e;
    int unsigned m;
    e.neg = sm && (((b >> (w - 1)) & 1) == 1);
    m     = e.neg ? ((32'd1 << w) - b) : b;
    e.bcd = '0;
    for (int i = 0; i < 5; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] b, input logic sm);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid    = 1'b1;
    bin_in      = b;
    signed_mode = sm;
    sb.push_back(model(b, BIN_W, sm));
    @(posedge clk); #1;
    in_valid    = 1'b0;
    bin_in      = 16'($urandom);
    signed_mode = 1'($urandom);
    check("in_ready_busy", in_ready, 0);
  endtask

  // Waits for out_valid, checks latency and result, optionally holds off out_ready.
  task automatic receive(input bit noise, input int hold);
    int   lat;
    exp_t e;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (noise) begin
        in_valid    = 1'b1;
        bin_in      = 16'($urandom);
        signed_mode = 1'($urandom);
      end
      if (out_valid) break;
      check("in_ready_shift", in_ready, 0);
      if (k == 40) lat = 41;
    end
    check("latency", lat, BIN_W);
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 1, 0);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check("bcd_out", bcd_out, e.bcd);
    check("neg", neg, e.neg);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (noise) begin
        in_valid = 1'b1;
        bin_in   = 16'($urandom);
      end
      check("hold_out_valid", out_valid, 1);
      check("hold_bcd_out", bcd_out, e.bcd);
      check("hold_neg", neg, e.neg);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_return", in_ready, 1);
    check("bcd_held_idle", bcd_out, e.bcd);
  endtask

  task automatic run8(input logic [7:0] b, input logic sm, input logic [11:0] eb, input logic en);
    int lat;
    @(negedge clk);
    check("in_ready_8", in_ready_8, 1);
    in_valid_8    = 1'b1;
    bin_in_8      = b;
    signed_mode_8 = sm;
    @(posedge clk); #1;
    in_valid_8 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (out_valid_8) break;
      if (k == 30) lat = 31;
    end
    check("latency_8", lat, 8);
    check("bcd_out_8", bcd_out_8, eb);
    check("neg_8", neg_8, en);
    @(posedge clk); #1;
    check("out_valid_drop_8", out_valid_8, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; bin_in = '0; signed_mode = 1'b0; out_ready = 1'b1;
    in_valid_8 = 1'b0; bin_in_8 = '0; signed_mode_8 = 1'b0; out_ready_8 = 1'b1;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd_out", bcd_out, 0);
    check("rst_neg", neg, 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h00FF, 1'b0); receive(1'b0, 0);
    send(16'h8000, 1'b1); receive(1'b0, 0);
    send(16'hFFFF, 1'b1); receive(1'b0, 0);
    send(16'hFFFF, 1'b0); receive(1'b0, 0);
    send(16'h0000, 1'b0); receive(1'b0, 0);
    send(16'h0000, 1'b1); receive(1'b0, 0);
    send(16'h7FFF, 1'b1); receive(1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      send(16'($urandom), 1'(r));
      receive(1'b0, 0);
    end

    // Backpressure with ignored in_valid noise, result -9999.
    out_ready = 1'b0;
    send(16'hD8F1, 1'b1);
    receive(1'b1, 10);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("single_handshake", out_valid, 0);
    end
    check("scoreboard_drained", sb.size(), 0);

    // Asynchronous reset in the middle of SHIFT.
    send(16'd54321, 1'b0);
    sb.delete();
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_bcd_out", bcd_out, 0);
    check("async_rst_neg", neg, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      check("aborted_no_valid", out_valid, 0);
    end
    send(16'd12345, 1'b0); receive(1'b0, 0);

    run8(8'h80, 1'b1, 12'h128, 1'b1);
    run8(8'hFF, 1'b0, 12'h255, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
